// File: rtl/logic_gates_bist_ctrl.sv
// logic_gates_bist_ctrl
// Built-in self-test sequencer for the two-input logic_gates unit. A run
// sweeps {GATE_A,GATE_B} through 00,01,10,11 (PASSES times). Each value is
// held for SETTLE_CYCLES cycles, and then the six gate outputs are sampled
// for one cycle and compared against golden values.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   start, abort      run request (sampled in IDLE) / cancel a run in progress
//   GATE_A, GATE_B    registered drive to the logic_gates A/B inputs
//   AND_IN..XNOR_IN   the six logic_gates outputs under test
//   busy              high in every state except IDLE
//   done              one-cycle pulse while in DONE
//   pass              err_vec==0 at run end; held until the next start
//   err_vec           sticky mismatch flags {AND,OR,XOR,NAND,NOR,XNOR}
//   fail_combo        {A,B} of the first mismatching sample of the run
//   state_dbg         current FSM state (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//
// Handshake: start is a level request. It is acted on only in IDLE, and only
// when abort is low in the same cycle. abort is acted on in SETTLE and SAMPLE
// and is ignored in IDLE and DONE.
module logic_gates_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       GATE_A,
  output logic       GATE_B,
  input  logic       AND_IN,
  input  logic       OR_IN,
  input  logic       XOR_IN,
  input  logic       NAND_IN,
  input  logic       NOR_IN,
  input  logic       XNOR_IN,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_vec,
  output logic [1:0] fail_combo,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] settle_q;
  logic [3:0] pass_cnt_q;
  logic [1:0] combo_q;
  logic       gate_a_q, gate_b_q;
  logic       pass_q;
  logic [5:0] err_q;
  logic [1:0] fail_q;

  logic       accept;
  logic       settle_end;
  logic       last_sample;
  logic [5:0] expected;
  logic [5:0] mism;
  logic [1:0] combo_next;

  assign accept      = start && !abort;
  assign settle_end  = (settle_q == 8'(SETTLE_CYCLES - 1));
  assign last_sample = (combo_q == 2'd3) && (pass_cnt_q == 4'(PASSES - 1));
  assign combo_next  = combo_q + 2'd1;

  // Golden values come from the A/B actually being driven.
  assign expected = {gate_a_q & gate_b_q, gate_a_q | gate_b_q, gate_a_q ^ gate_b_q,
                     ~(gate_a_q & gate_b_q), ~(gate_a_q | gate_b_q), ~(gate_a_q ^ gate_b_q)};
  assign mism     = expected ^ {AND_IN, OR_IN, XOR_IN, NAND_IN, NOR_IN, XNOR_IN};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SETTLE;
      S_SETTLE: begin
        if (abort)           state_d = S_IDLE;
        else if (settle_end) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)            state_d = S_IDLE;
        else if (last_sample) state_d = S_DONE;
        else                  state_d = S_SETTLE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_q   <= '0;
      pass_cnt_q <= '0;
      combo_q    <= '0;
      gate_a_q   <= 1'b0;
      gate_b_q   <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          gate_a_q <= 1'b0;
          gate_b_q <= 1'b0;
          if (accept) begin
            err_q      <= '0;
            fail_q     <= '0;
            pass_q     <= 1'b0;
            combo_q    <= '0;
            pass_cnt_q <= '0;
            settle_q   <= '0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            pass_q   <= 1'b0;
            settle_q <= '0;
          end else if (settle_end) begin
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          // The compare happens even in a cycle where abort is taken.
          err_q <= err_q | mism;
          // err_q is cleared at start, so zero here means nothing has failed yet.
          if ((err_q == 6'd0) && (mism != 6'd0)) fail_q <= combo_q;
          if (abort) begin
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            pass_q   <= 1'b0;
          end else if (last_sample) begin
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            // Verdict includes this final sample, so it is visible while done is high.
            pass_q   <= ((err_q | mism) == 6'd0);
          end else begin
            combo_q  <= combo_next;
            gate_a_q <= combo_next[1];
            gate_b_q <= combo_next[0];
            if (combo_q == 2'd3) pass_cnt_q <= pass_cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          gate_a_q <= 1'b0;
          gate_b_q <= 1'b0;
        end
        default: begin
          gate_a_q <= 1'b0;
          gate_b_q <= 1'b0;
        end
      endcase
    end
  end

  assign GATE_A     = gate_a_q;
  assign GATE_B     = gate_b_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_vec    = err_q;
  assign fail_combo = fail_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_logic_gates_bist_ctrl.sv
// Testbench for logic_gates_bist_ctrl. It drives the default instance against
// a behavioural gate model that can have its XOR node stuck at 0. A second
// instance with PASSES=2 and SETTLE_CYCLES=1 runs against a good model.
module tb_logic_gates_bist_ctrl;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance
  logic       start, abort, ga, gb;
  logic       and_o, or_o, xor_o, nand_o, nor_o, xnor_o;
  logic       busy, done, pass;
  logic [5:0] err_vec;
  logic [1:0] fail_combo, state_dbg;
  logic       xor_stuck;

  // In the fault model the XOR node is stuck, and XNOR is derived from it.
  assign and_o  = ga & gb;
  assign or_o   = ga | gb;
  assign xor_o  = xor_stuck ? 1'b0 : (ga ^ gb);
  assign nand_o = ~and_o;
  assign nor_o  = ~or_o;
  assign xnor_o = ~xor_o;

  logic_gates_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .GATE_A(ga), .GATE_B(gb),
    .AND_IN(and_o), .OR_IN(or_o), .XOR_IN(xor_o),
    .NAND_IN(nand_o), .NOR_IN(nor_o), .XNOR_IN(xnor_o),
    .busy(busy), .done(done), .pass(pass), .err_vec(err_vec),
    .fail_combo(fail_combo), .state_dbg(state_dbg)
  );

  // Second instance: two passes, one settle cycle
  logic       start2, abort2, ga2, gb2;
  logic       busy2, done2, pass2;
  logic [5:0] err_vec2;
  logic [1:0] fail_combo2, state_dbg2;

  logic_gates_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .GATE_A(ga2), .GATE_B(gb2),
    .AND_IN(ga2 & gb2), .OR_IN(ga2 | gb2), .XOR_IN(ga2 ^ gb2),
    .NAND_IN(~(ga2 & gb2)), .NOR_IN(~(ga2 | gb2)), .XNOR_IN(~(ga2 ^ gb2)),
    .busy(busy2), .done(done2), .pass(pass2), .err_vec(err_vec2),
    .fail_combo(fail_combo2), .state_dbg(state_dbg2)
  );

  // Checking
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: {pass, err_vec, fail_combo} pushed per expected run, popped on done
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("pass",       32'(pass),       32'(exp_e[8]));
        check_eq("err_vec",    32'(err_vec),    32'(exp_e[7:2]));
        check_eq("fail_combo", 32'(fail_combo), 32'(exp_e[1:0]));
      end
    end
  end

  // Driver tasks. Cycle 0 is the cycle in which start is first seen.
  // This task runs one default-instance run, checks the A/B sweep and the
  // done latency, and optionally re-pulses start while the run is busy.
  task automatic run1(input int exp_lat, input logic [8:0] exp_v, input int repulse_cyc);
    int cyc;
    bit got;
    logic [1:0] ec;
    exp_q.push_back(exp_v);
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = (cyc == repulse_cyc);
      if (cyc <= 12) begin
        ec = 2'((cyc - 1) / 3);
        check_eq("gate_seq", 32'({ga, gb}), 32'(ec));
      end
      if (done) begin
        got = 1'b1;
        check_eq("latency", 32'(cyc), 32'(exp_lat));
      end
    end
    if (!got) check_eq("done_timeout", 32'd0, 32'd1);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (done) return;
    end
    check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  int n;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; xor_stuck = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_err",  32'(err_vec), 32'd0);
    check_eq("rst_fc",   32'(fail_combo), 32'd0);
    check_eq("rst_gate", 32'({ga, gb}), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    idle_gap();

    // Good model, defaults
    run1(13, {1'b1, 6'b000000, 2'b00}, 0);
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("pass_held", 32'(pass), 32'd1);
    idle_gap();

    // XOR stuck at 0
    xor_stuck = 1'b1;
    run1(13, {1'b0, 6'b001001, 2'b01}, 0);
    idle_gap();

    // start together with abort in IDLE: no run, results untouched
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("start_abort_busy", 32'(busy), 32'd0);
    check_eq("start_abort_err",  32'(err_vec), 32'(6'b001001));
    idle_gap();

    // abort in the second SETTLE cycle of combo 10 (cycle 8)
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 8) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_gate", 32'({ga, gb}), 32'd0);
    check_eq("abort_pass", 32'(pass), 32'd0);
    check_eq("abort_err",  32'(err_vec), 32'(6'b001001));
    check_eq("abort_fc",   32'(fail_combo), 32'(2'b01));
    repeat (20) @(negedge clk);
    xor_stuck = 1'b0;
    run1(13, {1'b1, 6'b000000, 2'b00}, 0);
    idle_gap();

    // start re-pulsed while busy
    run1(13, {1'b1, 6'b000000, 2'b00}, 5);
    idle_gap();

    // reset while in SAMPLE of combo 01 with a fault present
    xor_stuck = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_eq("pre_rst_state", 32'(state_dbg), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_err",  32'(err_vec), 32'd0);
    check_eq("midrst_fc",   32'(fail_combo), 32'd0);
    check_eq("midrst_gate", 32'({ga, gb}), 32'd0);
    check_eq("midrst_pass", 32'(pass), 32'd0);
    rst_n = 1'b1;
    idle_gap();

    // start held high: back-to-back runs
    exp_q.push_back({1'b0, 6'b001001, 2'b01});
    exp_q.push_back({1'b0, 6'b001001, 2'b01});
    start = 1'b1;
    wait_done(n);
    check_eq("b2b_lat1", 32'(n), 32'd13);
    @(negedge clk);
    check_eq("b2b_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("b2b_busy",    32'(busy), 32'd1);
    check_eq("b2b_cleared", 32'(err_vec), 32'd0);
    start = 1'b0;
    wait_done(n);
    check_eq("b2b_lat2", 32'(n), 32'd12);
    xor_stuck = 1'b0;
    idle_gap();

    // PASSES=2, SETTLE_CYCLES=1 instance
    start2 = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      start2 = 1'b0;
      if (done2) break;
    end
    check_eq("p2_latency", 32'(n), 32'd17);
    check_eq("p2_pass",    32'(pass2), 32'd1);
    check_eq("p2_err",     32'(err_vec2), 32'd0);

    repeat (5) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
